// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Summary  : Register-hazard scoreboard for an in-order MIPS-like pipeline.
//             Tracks pending writes per GPR with 2-bit counters, stalls
//             decode on RAW hazards, counts stall cycles and flags protocol
//             or counter overflow/underflow errors (sticky until reset).
//  Options  : define WB_BYPASS_EN to let a read proceed when its only pending
//             write commits in the same cycle (register-file write-through).
//  Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_ins,
  input  logic        wb_valid,
  input  logic [31:0] wb_ins,
  input  logic [31:0] d_ins,
  output logic        dstall,
  output logic [31:0] busy_vec,
  output logic [15:0] stall_cnt,
  output logic        err
);

  // Opcode encodings that matter to hazard tracking
  localparam logic [5:0]  c_OP_RTYPE    = 6'b000000;
  localparam logic [5:0]  c_OP_BEQ      = 6'b000100;
  localparam logic [5:0]  c_OP_LW       = 6'b100011;
  localparam logic [5:0]  c_OP_SW       = 6'b101011;
  localparam logic [1:0]  c_CNT_MAX     = 2'd3;
  localparam logic [15:0] c_STALL_MAX   = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Instruction decode helpers. An all-zero word is a NOP and touches nothing,
  // even though its opcode field looks like an R-type.
  // --------------------------------------------------------------------------
  function automatic logic is_writer(input logic [31:0] ins);
    logic res;
    res = 1'b0;
    if (ins != 32'h0) begin
      case (ins[31:26])
        c_OP_RTYPE, c_OP_LW: res = 1'b1;
        default:             res = 1'b0;
      endcase
    end
    return res;
  endfunction

  function automatic logic [4:0] dest_reg(input logic [31:0] ins);
    // R-type writes rd, lw writes rt
    return (ins[31:26] == c_OP_RTYPE) ? ins[15:11] : ins[20:16];
  endfunction

  function automatic logic reads_rs(input logic [31:0] ins);
    logic res;
    res = 1'b0;
    if (ins != 32'h0) begin
      case (ins[31:26])
        c_OP_RTYPE, c_OP_BEQ, c_OP_SW, c_OP_LW: res = 1'b1;
        default:                                res = 1'b0;
      endcase
    end
    return res;
  endfunction

  function automatic logic reads_rt(input logic [31:0] ins);
    logic res;
    res = 1'b0;
    if (ins != 32'h0) begin
      case (ins[31:26])
        c_OP_RTYPE, c_OP_BEQ, c_OP_SW: res = 1'b1;
        default:                       res = 1'b0;
      endcase
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  r_cnt [1:31];
  logic [15:0] r_stall_cnt;
  logic        r_err;

  // --------------------------------------------------------------------------
  // Combinational nets
  // --------------------------------------------------------------------------
  logic        w_iss_wr;
  logic [4:0]  w_iss_dst;
  logic        w_wb_wr;
  logic [4:0]  w_wb_dst;
  logic [31:0] w_inc;
  logic [31:0] w_dec;
  logic [31:0] w_busy;
  logic [31:0] w_block;
  logic [31:0] w_ovf;
  logic [31:0] w_unf;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_rd_rs;
  logic        w_rd_rt;
  logic        w_dstall;
  logic        w_issue_violation;

  assign w_iss_wr  = is_writer(issue_ins);
  assign w_iss_dst = dest_reg(issue_ins);
  assign w_wb_wr   = is_writer(wb_ins);
  assign w_wb_dst  = dest_reg(wb_ins);

  assign w_rs    = d_ins[25:21];
  assign w_rt    = d_ins[20:16];
  assign w_rd_rs = reads_rs(d_ins);
  assign w_rd_rt = reads_rt(d_ins);

  // One-hot increment/decrement requests; register 0 is never tracked
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (issue_valid && w_iss_wr) begin
      w_inc[w_iss_dst] = 1'b1;
    end
    if (wb_valid && w_wb_wr) begin
      w_dec[w_wb_dst] = 1'b1;
    end
    w_inc[0] = 1'b0;
    w_dec[0] = 1'b0;
  end

  // Per-register busy, hazard-blocking and counter error conditions
  always_comb begin
    w_busy  = '0;
    w_block = '0;
    w_ovf   = '0;
    w_unf   = '0;
    for (int n = 1; n < 32; n++) begin
      w_busy[n] = (r_cnt[n] != 2'd0);
`ifdef WB_BYPASS_EN
      // A single pending write that commits this cycle is written through
      // the register file, so the reader sees the fresh value.
      w_block[n] = w_busy[n] && !((r_cnt[n] == 2'd1) && w_dec[n]);
`else
      w_block[n] = w_busy[n];
`endif
      w_ovf[n] = w_inc[n] && !w_dec[n] && (r_cnt[n] == c_CNT_MAX);
      w_unf[n] = w_dec[n] && !w_inc[n] && (r_cnt[n] == 2'd0);
    end
  end

  // RAW hazard on either source operand holds decode
  always_comb begin
    w_dstall = 1'b0;
    if (w_rd_rs && w_block[w_rs]) begin
      w_dstall = 1'b1;
    end
    if (w_rd_rt && w_block[w_rt]) begin
      w_dstall = 1'b1;
    end
  end

  assign w_issue_violation = issue_valid && w_dstall;

  // --------------------------------------------------------------------------
  // Pending-write counters, one per architectural register 1..31
  // --------------------------------------------------------------------------
  generate
    for (genvar n = 1; n < 32; n++) begin : g_cnt
      // Saturating up/down counter; simultaneous inc and dec cancel out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt[n] <= 2'd0;
        end else if (w_inc[n] && !w_dec[n]) begin
          if (r_cnt[n] != c_CNT_MAX) begin
            r_cnt[n] <= r_cnt[n] + 2'd1;
          end
        end else if (w_dec[n] && !w_inc[n]) begin
          if (r_cnt[n] != 2'd0) begin
            r_cnt[n] <= r_cnt[n] - 2'd1;
          end
        end
      end
    end
  endgenerate

  // Stall-cycle counter, saturating rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_dstall && (r_stall_cnt != c_STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Sticky error: counter overflow/underflow or issuing past a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((|w_ovf) || (|w_unf) || w_issue_violation) begin
      r_err <= 1'b1;
    end
  end

  assign dstall    = w_dstall;
  assign busy_vec  = w_busy;
  assign stall_cnt = r_stall_cnt;
  assign err       = r_err;

endmodule
`default_nettype wire
